// File: rtl/nx_ia_arb_pkg.sv
// Shared types for the indirect-access arbiter: arbitration state, access owner
// and the response tag carried alongside each read/compare through the RAM latency.
package nx_ia_arb_pkg;

   typedef enum logic {
      ARB_HW = 1'b0,
      ARB_SW = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_HW = 1'b0,
      OWN_SW = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
      logic   cmp;
   } rsp_tag_t;

   localparam rsp_tag_t RSP_TAG_IDLE = '{vld: 1'b0, owner: OWN_HW, cmp: 1'b0};

endpackage

// File: rtl/nx_ia_arb_rsp_pipe.sv
// Fixed-length delay line for response tags; a flush empties every stage on the
// next clock so nothing launched before it can ever produce a response.
module nx_ia_arb_rsp_pipe
   import nx_ia_arb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic     clk,
   input  logic     flush,
   input  rsp_tag_t tag_in,
   output rsp_tag_t tag_out
);

   rsp_tag_t stage_q [DEPTH];
   rsp_tag_t stage_d [DEPTH];

   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = RSP_TAG_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      stage_q <= stage_d;
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/nx_indirect_access_arb.sv
// Arbitrates one single-port table RAM between the datapath (priority) and the
// software indirect-access controller, with a starvation counter protecting software.
module nx_indirect_access_arb
   import nx_ia_arb_pkg::*;
#(
   parameter int ADDR_BITS   = 14,
   parameter int DATA_BITS   = 38,
   parameter int AINDEX_BITS = 13,
   parameter int RD_LATENCY  = 2,
   parameter int WAIT_BITS   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sw_cs,
   input  logic                   sw_ce,
   input  logic                   sw_we,
   input  logic [ADDR_BITS-1:0]   sw_add,
   input  logic [DATA_BITS-1:0]   sw_wdat,
   input  logic                   yield,
   input  logic                   sw_init,
   output logic                   grant,
   output logic                   rsp,
   output logic [DATA_BITS-1:0]   sw_rdat,
   output logic                   sw_match,
   output logic [AINDEX_BITS-1:0] sw_aindex,
   input  logic                   hw_req,
   input  logic                   hw_we,
   input  logic [ADDR_BITS-1:0]   hw_add,
   input  logic [DATA_BITS-1:0]   hw_wdat,
   output logic                   hw_gnt,
   output logic                   hw_rvld,
   output logic [DATA_BITS-1:0]   hw_rdat,
   output logic                   mem_cs,
   output logic                   mem_ce,
   output logic                   mem_we,
   output logic [ADDR_BITS-1:0]   mem_add,
   output logic [DATA_BITS-1:0]   mem_wdat,
   input  logic [DATA_BITS-1:0]   mem_rdat,
   input  logic                   mem_match,
   input  logic [AINDEX_BITS-1:0] mem_aindex
);

   localparam logic [WAIT_BITS-1:0] WAIT_MAX = '1;
   localparam logic [WAIT_BITS-1:0] WAIT_ONE = WAIT_BITS'(1);

   arb_state_e             state_q, state_d;
   logic [WAIT_BITS-1:0]   wait_cnt_q, wait_cnt_d;
   logic                   mem_cs_q, mem_cs_d;
   logic                   mem_ce_q, mem_ce_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_BITS-1:0]   mem_add_q, mem_add_d;
   logic [DATA_BITS-1:0]   mem_wdat_q, mem_wdat_d;
   logic [DATA_BITS-1:0]   sw_rdat_q, sw_rdat_d;
   logic [DATA_BITS-1:0]   hw_rdat_q, hw_rdat_d;
   logic                   sw_match_q, sw_match_d;
   logic [AINDEX_BITS-1:0] sw_aindex_q, sw_aindex_d;
   logic                   hw_ok;
   logic                   sw_rsp;
   logic                   hw_rsp;
   rsp_tag_t               launch_tag;
   rsp_tag_t               done_tag;

   // The datapath normally wins; ARB_SW flips priority for exactly one decision.
   always_comb begin
      hw_ok  = hw_req && !sw_init;
      grant  = 1'b0;
      hw_gnt = 1'b0;
      if (!rst) begin
         if (state_q == ARB_SW) begin
            grant  = sw_cs;
            hw_gnt = !sw_cs && hw_ok;
         end else begin
            hw_gnt = hw_ok;
            grant  = !hw_ok && sw_cs;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_HW: if ((yield && sw_cs) || (wait_cnt_q == WAIT_MAX)) state_d = ARB_SW;
         ARB_SW: if (grant || !sw_cs) state_d = ARB_HW;
         default: state_d = ARB_HW;
      endcase

      if (!sw_cs || grant) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Writes launch no tag, so only reads and compares come back as responses.
   always_comb begin
      mem_cs_d   = grant || hw_gnt;
      mem_ce_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_add_d  = '0;
      mem_wdat_d = '0;
      launch_tag = RSP_TAG_IDLE;
      if (grant) begin
         mem_ce_d         = sw_ce;
         mem_we_d         = sw_we;
         mem_add_d        = sw_add;
         mem_wdat_d       = sw_wdat;
         launch_tag.vld   = sw_ce || !sw_we;
         launch_tag.owner = OWN_SW;
         launch_tag.cmp   = sw_ce;
      end else if (hw_gnt) begin
         mem_we_d         = hw_we;
         mem_add_d        = hw_add;
         mem_wdat_d       = hw_wdat;
         launch_tag.vld   = !hw_we;
         launch_tag.owner = OWN_HW;
      end
   end

   nx_ia_arb_rsp_pipe #(
      .DEPTH (RD_LATENCY + 1)
   ) u_rsp_pipe (
      .clk     (clk),
      .flush   (rst),
      .tag_in  (launch_tag),
      .tag_out (done_tag)
   );

   // The tag leaves the pipe in the cycle the RAM data is valid, so data is
   // forwarded straight through and also held for the following cycles.
   always_comb begin
      sw_rsp      = !rst && done_tag.vld && (done_tag.owner == OWN_SW);
      hw_rsp      = !rst && done_tag.vld && (done_tag.owner == OWN_HW);
      sw_rdat_d   = sw_rdat_q;
      sw_match_d  = sw_match_q;
      sw_aindex_d = sw_aindex_q;
      hw_rdat_d   = hw_rdat_q;
      if (sw_rsp && !done_tag.cmp) sw_rdat_d = mem_rdat;
      if (sw_rsp && done_tag.cmp) begin
         sw_match_d  = mem_match;
         sw_aindex_d = mem_aindex;
      end
      if (hw_rsp) hw_rdat_d = mem_rdat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_HW;
         wait_cnt_q  <= '0;
         mem_cs_q    <= 1'b0;
         mem_ce_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_add_q   <= '0;
         mem_wdat_q  <= '0;
         sw_rdat_q   <= '0;
         sw_match_q  <= 1'b0;
         sw_aindex_q <= '0;
         hw_rdat_q   <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_cs_q    <= mem_cs_d;
         mem_ce_q    <= mem_ce_d;
         mem_we_q    <= mem_we_d;
         mem_add_q   <= mem_add_d;
         mem_wdat_q  <= mem_wdat_d;
         sw_rdat_q   <= sw_rdat_d;
         sw_match_q  <= sw_match_d;
         sw_aindex_q <= sw_aindex_d;
         hw_rdat_q   <= hw_rdat_d;
      end
   end

   assign mem_cs    = mem_cs_q;
   assign mem_ce    = mem_ce_q;
   assign mem_we    = mem_we_q;
   assign mem_add   = mem_add_q;
   assign mem_wdat  = mem_wdat_q;
   assign rsp       = sw_rsp;
   assign hw_rvld   = hw_rsp;
   assign sw_rdat   = sw_rdat_d;
   assign sw_match  = sw_match_d;
   assign sw_aindex = sw_aindex_d;
   assign hw_rdat   = hw_rdat_d;

endmodule
